note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Programmable melody player sitting directly upstream of the square-wave tone generator.
//  Holds a small pattern RAM of {note, beats} steps and plays it at a fixed tempo.
//  Drives the generator's 3-bit note code and en, with a short silent gap per step.
//  Supports one-shot or looped playback, start/stop control and live pattern edits.
// PARAMETERS
//  BEAT_DIV    12_500_000  clk cycles per beat (0.25 s at 50 MHz); must be > GAP_CYCLES
//  GAP_CYCLES  1_250_000   trailing cycles of each step with en=0 (articulation gap)
//  SONG_LEN    16          pattern RAM depth (steps); AW = $clog2(SONG_LEN)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-high reset
//  wr_en     in   1   pattern RAM write strobe
//  wr_addr   in   AW  RAM write address
//  wr_data   in   6   {note[5:3], beats[2:0]}; note 0=rest, 1..7=A,B,C,D,E,F,G; beats 0=end marker
//  start     in   1   pulse: begin playback at step 0 (ignored while busy)
//  stop      in   1   pulse: abort playback
//  loop      in   1   level: 1=wrap to step 0 at song end, 0=stop at song end
//  note      out  3   note code to tone generator
//  en        out  1   tone enable to tone generator
//  step      out  AW  index of step currently playing
//  busy      out  1   1 while state != IDLE
//  done      out  1   one-cycle pulse when one-shot playback ends
// BEHAVIOUR
//  - One clock domain; one clock and one synchronous active-high reset (clk, rst).
//  - Reset: state=IDLE, note=0, en=0, step=0, busy=0, done=0, all RAM entries=0, counters=0.
//  - RAM: registered write on wr_en, any state. A step fetch in the same cycle as a write
//    to that address sees the new data (write-through).
//  - States: IDLE, PLAY, GAP.
//  - IDLE: note=0, en=0. On start (and not stop): fetch step 0. If beats==0 -> done pulse,
//    remain IDLE (covers loop=1: empty song never spins). Else next cycle PLAY with
//    note=entry note, step=0, cycle counter=0. Start-to-note latency: 1 cycle.
//  - PLAY: en=1 if note!=0, else 0 (rests silent). Lasts beats*BEAT_DIV-GAP_CYCLES cycles -> GAP.
//  - GAP: en=0, note held. Lasts GAP_CYCLES cycles, then fetch next step in the same cycle.
//  - Step length is exactly beats*BEAT_DIV cycles; no idle cycles between steps.
//  - Cycle counter wide enough for 7*BEAT_DIV; no wrap within a step.
//  - Next step: idx = step+1. If step==SONG_LEN-1 or entry[idx].beats==0 -> song end.
//  - Song end: loop=1 -> refetch step 0 (if its beats==0 -> IDLE + done); loop=0 -> IDLE,
//    note=0, en=0, done=1 for one cycle. loop sampled at song end only.
//  - stop: from any state, next cycle IDLE, note=0, en=0, step=0, no done pulse.
//    stop and start in the same cycle: stop wins. start while busy: ignored.
//  - rst mid-playback: same as reset values next cycle; RAM cleared.
//  - Edits to the playing step do not alter the current note/length; they apply on next fetch.
// TESTING (bench: BEAT_DIV=8, GAP_CYCLES=2, SONG_LEN=4)
//  - RAM {A,1},{C,2},{0,0}; loop=0; start -> note=1 en=1 for 6 cyc, en=0 2 cyc;
//    note=3 en=1 14 cyc, en=0 2 cyc; then note=0, done pulse 1 cyc, busy=0.
//  - Same RAM, loop=1 -> after step 1 GAP, note=1 again at step 0 with zero idle cycles;
//    runs until stop; stop -> next cycle note=0 en=0 busy=0, no done.
//  - RAM all 4 steps {G,1}; loop=0 -> steps 0..3 played (32 cyc total), ends at SONG_LEN wrap, done.
//  - RAM entry0 {x,0}; start with loop=1 -> done pulse next cycle, busy never set.
//  - RAM {0,1},{E,1},{0,0}: rest step -> en=0 8 cyc with note=0; then note=5 en=1 6 cyc.
//  - start+stop same cycle -> stays IDLE; start during PLAY ignored; rst during PLAY -> all
//    outputs 0 next cycle and readback play of step 0 ends immediately (RAM cleared).

Source files
------------

// File: rtl/note_seq_if.sv
// Control, pattern-write and tone-generator signals of the melody player.
// dbg_state mirrors the FSM state (0=IDLE, 1=PLAY, 2=GAP) so checkers can bind to it.
interface note_seq_if #(
  parameter int AW = 4
) ();
  // Plain level/strobe interface: no valid/ready handshake. wr_en is a one-cycle
  // write strobe, start/stop are one-cycle pulses, loop is a level.
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_data;
  logic          start;
  logic          stop;
  logic          loop;
  logic [2:0]    note;
  logic          en;
  logic [AW-1:0] step;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop,
    input  note, en, step, busy, done, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop,
    output note, en, step, busy, done, dbg_state
  );
endinterface

// File: rtl/note_sequencer.sv
// Melody player: steps through a {note, beats} pattern RAM at a fixed tempo and
// drives a tone generator's note code and enable, with a silent gap ending every step.
module note_sequencer #(
  parameter int BEAT_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 1_250_000,
  parameter int SONG_LEN   = 16,
  parameter int AW         = $clog2(SONG_LEN)
) (
  input logic       clk,
  input logic       rst,
  note_seq_if.slave bus
);

  localparam int CW = $clog2(7 * BEAT_DIV + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    note_q, note_d;
  logic [2:0]    beats_q, beats_d;
  logic [AW-1:0] step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [5:0]    ram_q [SONG_LEN];

  logic [AW-1:0] nx_idx;
  logic [5:0]    ent0;
  logic [5:0]    ent_nx;
  logic          song_end;
  logic [CW-1:0] step_len;
  logic [CW-1:0] play_last;
  logic [CW-1:0] step_last;

  logic          load;
  logic [AW-1:0] load_idx;
  logic [5:0]    load_ent;

  // Pattern RAM; a fetch in the same cycle as a write to that address sees the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SONG_LEN; i++) begin
        ram_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      ram_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign nx_idx   = step_q + AW'(1);
  assign ent0     = (bus.wr_en && bus.wr_addr == '0) ? bus.wr_data : ram_q[0];
  assign ent_nx   = (bus.wr_en && bus.wr_addr == nx_idx) ? bus.wr_data : ram_q[nx_idx];
  assign song_end = (step_q == AW'(SONG_LEN - 1)) || (ent_nx[2:0] == 3'd0);

  // Step timing uses the beats latched at fetch, so live edits only apply on the next fetch.
  assign step_len  = CW'(beats_q) * CW'(BEAT_DIV);
  assign play_last = step_len - CW'(GAP_CYCLES) - CW'(1);
  assign step_last = step_len - CW'(1);

  always_comb begin
    state_d  = state_q;
    note_d   = note_q;
    beats_d  = beats_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_idx = '0;
    load_ent = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (ent0[2:0] == 3'd0) begin
            done_d = 1'b1;
          end else begin
            load     = 1'b1;
            load_idx = '0;
            load_ent = ent0;
          end
        end
      end

      ST_PLAY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == play_last) begin
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == step_last) begin
          if (!song_end) begin
            load     = 1'b1;
            load_idx = nx_idx;
            load_ent = ent_nx;
          end else if (bus.loop && ent0[2:0] != 3'd0) begin
            load     = 1'b1;
            load_idx = '0;
            load_ent = ent0;
          end else begin
            state_d = ST_IDLE;
            note_d  = 3'd0;
            step_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        note_d  = 3'd0;
        step_d  = '0;
        cnt_d   = '0;
      end
    endcase

    if (load) begin
      state_d = ST_PLAY;
      note_d  = load_ent[5:3];
      beats_d = load_ent[2:0];
      step_d  = load_idx;
      cnt_d   = '0;
    end

    // stop overrides everything, including a same-cycle start or song end.
    if (bus.stop) begin
      state_d = ST_IDLE;
      note_d  = 3'd0;
      step_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      note_q  <= 3'd0;
      beats_q <= 3'd0;
      step_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      beats_q <= beats_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.note      = note_q;
  assign bus.en        = (state_q == ST_PLAY) && (note_q != 3'd0);
  assign bus.step      = step_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a step-timing model checked every cycle, plus
// directed songs with hand-counted note/gap/done figures.
module tb_note_sequencer;

  localparam int BD = 8;
  localparam int GC = 2;
  localparam int SL = 4;

  logic clk;
  logic rst;
  logic check_on;

  int n_checks;
  int n_errors;

  note_seq_if #(.AW(2)) bus ();

  note_sequencer #(
    .BEAT_DIV  (BD),
    .GAP_CYCLES(GC),
    .SONG_LEN  (SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [5:0] m_ram [SL];
  logic       m_play  = 1'b0;
  logic [2:0] m_note  = 3'd0;
  logic [2:0] m_beats = 3'd0;
  int         m_step  = 0;
  int         m_t     = 0;
  logic       m_done  = 1'b0;

  task automatic begin_step(input int idx);
    m_play  = 1'b1;
    m_step  = idx;
    m_note  = m_ram[idx][5:3];
    m_beats = m_ram[idx][2:0];
    m_t     = 0;
  endtask

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      for (int i = 0; i < SL; i++) m_ram[i] = '0;
      m_play = 1'b0; m_note = 3'd0; m_beats = 3'd0;
      m_step = 0;    m_t = 0;       m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (bus.wr_en) m_ram[bus.wr_addr] = bus.wr_data;
      if (bus.stop) begin
        m_play = 1'b0; m_note = 3'd0; m_step = 0;
      end else if (!m_play) begin
        if (bus.start) begin
          if (m_ram[0][2:0] == 3'd0) m_done = 1'b1;
          else begin_step(0);
        end
      end else begin
        m_t++;
        if (m_t == int'(m_beats) * BD) begin
          nxt = m_step + 1;
          if (nxt >= SL || m_ram[nxt][2:0] == 3'd0) begin
            if (bus.loop && m_ram[0][2:0] != 3'd0) begin
              begin_step(0);
            end else begin
              m_play = 1'b0; m_note = 3'd0; m_step = 0; m_done = 1'b1;
            end
          end else begin
            begin_step(nxt);
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      chk("note", 32'(bus.note), 32'(m_note));
      chk("en", 32'(bus.en), 32'(m_play && m_note != 3'd0 && m_t < int'(m_beats) * BD - GC));
      chk("step", 32'(bus.step), 32'(m_step));
      chk("busy", 32'(bus.busy), 32'(m_play));
      chk("done", 32'(bus.done), 32'(m_done));
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  int en_cnt [8];
  int c_busy, c_gap, c_done;

  task automatic clr_counts();
    for (int i = 0; i < 8; i++) en_cnt[i] = 0;
    c_busy = 0; c_gap = 0; c_done = 0;
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      if (bus.en) en_cnt[bus.note]++;
      if (bus.busy) c_busy++;
      if (bus.busy && !bus.en) c_gap++;
      if (bus.done) c_done++;
      @(negedge clk);
    end
  endtask

  task automatic write_ram(input int a, input logic [5:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = 2'(a); bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.loop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0; check_on = 1'b0;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    repeat (2) @(negedge clk);
    check_on = 1'b1;
    chk("rst_note", 32'(bus.note), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_en", 32'(bus.en), 0);
    rst = 1'b0;
    @(negedge clk);

    // one-shot {A,1},{C,2},{0,0}
    write_ram(0, 6'b001_001); write_ram(1, 6'b011_010); write_ram(2, 6'b000_000);
    pulse_start();
    chk("t1_first_note", 32'(bus.note), 1);
    clr_counts(); run_count(40);
    chk("t1_en_A", en_cnt[1], 6);
    chk("t1_en_C", en_cnt[3], 14);
    chk("t1_busy", c_busy, 24);
    chk("t1_gap", c_gap, 4);
    chk("t1_done", c_done, 1);

    // looped, with a live edit of step 0 while step 1 plays
    bus.loop = 1'b1;
    pulse_start();
    run_count(8);
    chk("t2_step1", 32'(bus.step), 1);
    write_ram(0, 6'b010_001);
    run_count(15);
    chk("t2_wrap_note", 32'(bus.note), 2);
    chk("t2_wrap_step", 32'(bus.step), 0);
    chk("t2_wrap_en", 32'(bus.en), 1);
    pulse_stop();
    chk("t2_stop_busy", 32'(bus.busy), 0);
    chk("t2_stop_en", 32'(bus.en), 0);
    clr_counts(); run_count(4);
    chk("t2_no_done", c_done, 0);

    // four {G,1} steps, ends at the RAM wrap
    do_reset();
    for (int i = 0; i < SL; i++) write_ram(i, 6'b111_001);
    pulse_start();
    clr_counts(); run_count(36);
    chk("t3_en_G", en_cnt[7], 24);
    chk("t3_busy", c_busy, 32);
    chk("t3_gap", c_gap, 8);
    chk("t3_done", c_done, 1);

    // empty song with loop=1
    do_reset();
    write_ram(0, 6'b101_000);
    bus.loop = 1'b1;
    pulse_start();
    chk("t4_done", 32'(bus.done), 1);
    clr_counts(); run_count(6);
    chk("t4_busy", c_busy, 0);
    chk("t4_done_cnt", c_done, 1);

    // rest step then E
    do_reset();
    write_ram(0, 6'b000_001); write_ram(1, 6'b101_001);
    pulse_start();
    chk("t5_rest_note", 32'(bus.note), 0);
    chk("t5_rest_busy", 32'(bus.busy), 1);
    clr_counts(); run_count(20);
    chk("t5_en_rest", en_cnt[0], 0);
    chk("t5_en_E", en_cnt[5], 6);
    chk("t5_gap", c_gap, 10);
    chk("t5_done", c_done, 1);

    // start+stop together, start while busy, rst mid-play
    do_reset();
    write_ram(0, 6'b001_001); write_ram(1, 6'b011_010);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("t6_startstop_busy", 32'(bus.busy), 0);
    pulse_start();
    run_count(3);
    pulse_start();
    clr_counts(); run_count(21);
    chk("t6_ignored_busy", c_busy, 20);
    chk("t6_ignored_done", c_done, 1);
    pulse_start();
    run_count(3);
    do_reset();
    chk("t6_rst_note", 32'(bus.note), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_step", 32'(bus.step), 0);
    pulse_start();
    chk("t6_cleared_done", 32'(bus.done), 1);
    chk("t6_cleared_busy", 32'(bus.busy), 0);
    run_count(3);

    check_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
